// File: rtl/ysyx_220053_exu_mc.sv
// ---------------------------------------------------------------------------
// ysyx_220053_exu_mc
// Multi-cycle integer execute unit with a private register file.
//
// One operation is in flight at a time. ALU ops take one EXEC cycle after
// the accept edge. MUL is a shift-add multiplier retiring one multiplier bit
// per cycle (XLEN cycles, or 32 in word mode), followed by a WB cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake (ready only in IDLE)
//   op, word, alusrcb   operation, 32-bit word mode, B-operand select
//   rs1, rs2, rd, imm   register addresses and immediate
//   flush               abort the in-flight operation (no write, no done)
//   busy                an operation is in flight
//   done, result        one-cycle completion pulse and last result
//   dbg_addr, dbg_data  combinational register-file read port
// ---------------------------------------------------------------------------
module ysyx_220053_exu_mc #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            word,
  input  logic            alusrcb,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  // Word mode only means something when the datapath is wider than 32 bits.
  localparam bit HAS_WORD = (XLEN > 32);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_regs [NREG];
  logic [3:0]      r_op;
  logic            r_word;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_a;     // operand A; doubles as the shifting multiplicand
  logic [XLEN-1:0] r_b;     // operand B; doubles as the shifting multiplier
  logic [XLEN-1:0] r_acc;   // product accumulator
  logic [CW-1:0]   r_cnt;   // multiply iteration counter

  logic            w_word_eff;
  logic            w_rsv;
  logic [31:0]     w_a32, w_b32, w_r32;
  logic [XLEN-1:0] w_r64, w_alu, w_mul_res, w_fin;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic [CW-1:0]   w_last;
  logic            w_we;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign in_ready   = (r_state == IDLE);
  assign busy       = !in_ready;
  assign w_word_eff = r_word & HAS_WORD;
  assign w_rsv      = (r_op > OP_MUL);
  assign w_a32      = r_a[31:0];
  assign w_b32      = r_b[31:0];
  assign w_rs1_val  = (rs1 == '0) ? '0 : r_regs[rs1];
  assign w_rs2_val  = (rs2 == '0) ? '0 : r_regs[rs2];
  assign dbg_data   = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

  // Both the 32-bit and full-width results are formed; word mode picks the
  // 32-bit one and sign-extends it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_r32 = '0;
    w_r64 = '0;
    case (r_op)
      OP_ADD:  begin w_r32 = w_a32 + w_b32; w_r64 = r_a + r_b; end
      OP_SUB:  begin w_r32 = w_a32 - w_b32; w_r64 = r_a - r_b; end
      OP_AND:  begin w_r32 = w_a32 & w_b32; w_r64 = r_a & r_b; end
      OP_OR:   begin w_r32 = w_a32 | w_b32; w_r64 = r_a | r_b; end
      OP_XOR:  begin w_r32 = w_a32 ^ w_b32; w_r64 = r_a ^ r_b; end
      OP_SLL:  begin w_r32 = w_a32 << w_b32[4:0]; w_r64 = r_a << r_b[SW-1:0]; end
      OP_SRL:  begin w_r32 = w_a32 >> w_b32[4:0]; w_r64 = r_a >> r_b[SW-1:0]; end
      OP_SRA:  begin
        w_r32 = $signed(w_a32) >>> w_b32[4:0];
        w_r64 = $signed(r_a) >>> r_b[SW-1:0];
      end
      OP_SLT:  begin
        w_r32 = {31'd0, $signed(w_a32) < $signed(w_b32)};
        w_r64 = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(r_b)};
      end
      OP_SLTU: begin
        w_r32 = {31'd0, w_a32 < w_b32};
        w_r64 = {{(XLEN-1){1'b0}}, r_a < r_b};
      end
      default: begin w_r32 = '0; w_r64 = '0; end  // reserved ops yield 0
    endcase
  end

  assign w_alu     = w_word_eff ? sext32(w_r32) : w_r64;
  assign w_mul_res = w_word_eff ? sext32(r_acc[31:0]) : r_acc;
  assign w_last    = w_word_eff ? CW'(31) : CW'(XLEN - 1);
  assign w_fin     = (r_state == WB) ? w_mul_res : w_alu;
  assign w_we      = !flush && (r_rd != '0) &&
                     (((r_state == EXEC) && !w_rsv) || (r_state == WB));

  // NOTE: the register file is cleared by reset, so it is built from flops
  // with an async clear rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[r_rd] <= w_fin;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_word  <= 1'b0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          // flush is deliberately ignored here: it never blocks an accept.
          if (in_valid) begin
            r_op    <= op;
            r_word  <= word;
            r_rd    <= rd;
            r_a     <= w_rs1_val;
            r_b     <= alusrcb ? imm : w_rs2_val;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= (op == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          r_state <= IDLE;
          if (!flush) begin
            result <= w_alu;
            done   <= 1'b1;
          end
        end
        MUL: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == w_last) r_state <= WB;
          end
        end
        WB: begin
          r_state <= IDLE;
          if (!flush) begin
            result <= w_mul_res;
            done   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220053_exu_mc.sv
// ---------------------------------------------------------------------------
// tb_ysyx_220053_exu_mc
// Directed self-checking bench for the multi-cycle execute unit. Inputs are
// driven on the falling edge, outputs sampled on the falling edge (or 1 ns
// after a change for the combinational debug port).
// ---------------------------------------------------------------------------
module tb_ysyx_220053_exu_mc;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic            word;
  logic            alusrcb;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] imm;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  ysyx_220053_exu_mc #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .word     (word),
    .alusrcb  (alusrcb),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .imm      (imm),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: presents one instruction, lets the next rising
  // edge accept it, and returns at the following falling edge.
  task automatic issue(input logic [3:0] o, input logic w, input logic src,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic [63:0] im, input logic fl);
    op = o; word = w; alusrcb = src; rs1 = a; rs2 = b; rd = d; imm = im;
    flush = fl; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // lat counts falling edges since the accept edge (1 = first after accept).
  task automatic wait_done(input int limit, output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < limit) begin
      if (!in_ready) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [63:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic w,
                        input logic src, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [63:0] im,
                        input logic [63:0] exp_res, input logic [63:0] exp_reg,
                        input int exp_lat, output int busy_cnt);
    int lat;
    logic [63:0] v;
    issue(o, w, src, a, b, d, im, 1'b0);
    wait_done(200, lat, busy_cnt);
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    read_reg(d, v);
    check({tag, " reg"}, v, exp_reg);
    @(negedge clk);
    check({tag, " done width"}, done, 0);
  endtask

  initial begin
    int bc, lat, dn;
    logic [63:0] v;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; word = 1'b0;
    alusrcb = 1'b0; rs1 = '0; rs2 = '0; rd = '0; imm = '0; dbg_addr = 5'd1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst dbg x1", dbg_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready first edge", in_ready, 1);
    @(negedge clk);

    // Basic ALU, operand loading via ADD x0 + imm
    run_op("ld x1", 4'd0, 0, 1, 5'd0, 5'd0, 5'd1, 64'd5, 64'd5, 64'd5, 2, bc);
    run_op("addi neg", 4'd0, 0, 1, 5'd1, 5'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFD,
           64'd2, 64'd2, 2, bc);
    run_op("ld x3", 4'd0, 0, 1, 5'd0, 5'd0, 5'd3, 64'hFFFF_FFFF,
           64'hFFFF_FFFF, 64'hFFFF_FFFF, 2, bc);
    run_op("ld x4", 4'd0, 0, 1, 5'd0, 5'd0, 5'd4, 64'd3, 64'd3, 64'd3, 2, bc);

    // Full-width multiply: 64 iterations + WB
    run_op("mul", 4'd10, 0, 0, 5'd3, 5'd4, 5'd5, 64'd0,
           64'h2_FFFF_FFFD, 64'h2_FFFF_FFFD, 66, bc);
    check("mul busy cycles", bc, 65);

    // Word-mode and shifts
    run_op("ld x1b", 4'd0, 0, 1, 5'd0, 5'd0, 5'd1, 64'h4000_0000,
           64'h4000_0000, 64'h4000_0000, 2, bc);
    run_op("sllw", 4'd5, 1, 1, 5'd1, 5'd0, 5'd6, 64'd1,
           64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 2, bc);
    run_op("add rd0", 4'd0, 0, 1, 5'd2, 5'd0, 5'd0, 64'd10, 64'd12, 64'd0, 2, bc);
    run_op("sub", 4'd1, 0, 0, 5'd2, 5'd4, 5'd7, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, bc);
    run_op("srl", 4'd6, 0, 1, 5'd7, 5'd0, 5'd8, 64'd60, 64'hF, 64'hF, 2, bc);
    run_op("sra", 4'd7, 0, 1, 5'd6, 5'd0, 5'd9, 64'd4,
           64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_F800_0000, 2, bc);
    run_op("slt", 4'd8, 0, 0, 5'd7, 5'd4, 5'd10, 64'd0, 64'd1, 64'd1, 2, bc);
    run_op("sltu", 4'd9, 0, 0, 5'd7, 5'd4, 5'd11, 64'd0, 64'd0, 64'd0, 2, bc);
    run_op("sll mask", 4'd5, 0, 1, 5'd4, 5'd0, 5'd12, 64'd65, 64'd6, 64'd6, 2, bc);
    run_op("addw", 4'd0, 1, 1, 5'd3, 5'd0, 5'd13, 64'd2, 64'd1, 64'd1, 2, bc);
    run_op("xor", 4'd4, 0, 1, 5'd3, 5'd0, 5'd14, 64'hF0,
           64'hFFFF_FF0F, 64'hFFFF_FF0F, 2, bc);
    run_op("and", 4'd2, 0, 1, 5'd3, 5'd0, 5'd15, 64'hFF00, 64'hFF00, 64'hFF00, 2, bc);
    run_op("or", 4'd3, 0, 1, 5'd4, 5'd0, 5'd16, 64'h10, 64'h13, 64'h13, 2, bc);
    run_op("srlw", 4'd6, 1, 1, 5'd6, 5'd0, 5'd18, 64'd4,
           64'h0800_0000, 64'h0800_0000, 2, bc);
    run_op("mulw", 4'd10, 1, 0, 5'd3, 5'd4, 5'd17, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 34, bc);
    check("mulw busy cycles", bc, 33);

    // Reserved op: result 0, x3 untouched
    run_op("reserved", 4'd12, 0, 1, 5'd3, 5'd0, 5'd3, 64'd5,
           64'd0, 64'hFFFF_FFFF, 2, bc);

    // Back-to-back accepts, second op reads the first one's result
    issue(4'd0, 0, 1, 5'd0, 5'd0, 5'd19, 64'd7, 1'b0);
    wait_done(20, lat, bc);
    check("b2b first done", done, 1);
    check("b2b ready in done", in_ready, 1);
    issue(4'd0, 0, 1, 5'd19, 5'd0, 5'd20, 64'd1, 1'b0);
    wait_done(20, lat, bc);
    check("b2b second done", done, 1);
    check("b2b second latency", lat, 2);
    check("b2b second result", result, 64'd8);
    @(negedge clk);

    // flush coinciding with accept does not block it
    issue(4'd0, 0, 1, 5'd0, 5'd0, 5'd21, 64'h55, 1'b1);
    wait_done(20, lat, bc);
    check("flush@accept done", done, 1);
    check("flush@accept result", result, 64'h55);
    @(negedge clk);

    // in_valid while busy is ignored
    issue(4'd10, 0, 0, 5'd4, 5'd4, 5'd22, 64'd0, 1'b0);
    op = 4'd0; alusrcb = 1'b1; rs1 = 5'd0; rd = 5'd23; imm = 64'h77; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_done(100, lat, bc);
    check("ignore done", done, 1);
    check("ignore result", result, 64'd9);
    read_reg(5'd22, v);
    check("ignore x22", v, 64'd9);
    read_reg(5'd23, v);
    check("ignore x23", v, 64'd0);
    @(negedge clk);

    // flush 10 cycles into MUL
    issue(4'd10, 0, 0, 5'd4, 5'd4, 5'd5, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush ready", in_ready, 1);
    check("flush done", done, 0);
    dn = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("flush no done", dn, 0);
    check("flush result kept", result, 64'd9);
    read_reg(5'd5, v);
    check("flush x5 kept", v, 64'h2_FFFF_FFFD);
    @(negedge clk);
    run_op("post flush add", 4'd0, 0, 1, 5'd0, 5'd0, 5'd24, 64'h99,
           64'h99, 64'h99, 2, bc);

    // Reset in the middle of a MUL
    issue(4'd10, 0, 0, 5'd3, 5'd4, 5'd25, 64'd0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ready", in_ready, 1);
    check("midrst done", done, 0);
    check("midrst result", result, 0);
    for (int i = 0; i < NREG; i++) begin
      read_reg(5'(i), v);
      check($sformatf("midrst x%0d", i), v, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst ready after", in_ready, 1);
    @(negedge clk);
    run_op("post reset add", 4'd0, 0, 1, 5'd0, 5'd0, 5'd1, 64'd3, 64'd3, 64'd3, 2, bc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
